// File: rtl/data_mem_ctrl.sv
// ============================================================================
//  data_mem_ctrl : byte/half/word load-store controller over a register-array
//                  data memory, with programmable wait states.
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t       state_q;
   logic [2:0]   cnt_q;
   logic         we_q;
   logic         uns_q;
   logic         fault_q;
   logic         err_q;
   logic [1:0]   size_q;
   logic [1:0]   off_q;
   logic [AW-1:0] idx_q;
   logic [31:0]  wdata_q;
   logic [31:0]  rdata_q;

   logic [31:0]  mem_q [DEPTH_WORDS] = '{default: 32'h0};

   logic         illegal_d;
   logic         range_d;
   logic         access_d;
   logic         wr_en_d;
   logic [3:0]   st_mask_d;
   logic [31:0]  st_data_d;
   logic [31:0]  ld_shift_d;
   logic [31:0]  ld_val_d;

   always_comb begin
      illegal_d = (size == 2'b11)
               || (size == 2'b01 && addr[0])
               || (size == 2'b10 && addr[1:0] != 2'b00);
      range_d   = |addr[31:AW+2];
      access_d  = (state_q == S_WAIT) && (cnt_q == 3'd0) && !fault_q;
      wr_en_d   = access_d && we_q;
   end

   // Store lane steering: data is right-aligned on input, shifted into its lanes here.
   always_comb begin
      case (size_q)
         2'b00: begin
            st_mask_d = 4'b0001 << off_q;
            st_data_d = {24'h0, wdata_q[7:0]} << {off_q, 3'b000};
         end
         2'b01: begin
            st_mask_d = 4'b0011 << {off_q[1], 1'b0};
            st_data_d = {16'h0, wdata_q[15:0]} << {off_q[1], 4'b0000};
         end
         default: begin
            st_mask_d = 4'b1111;
            st_data_d = wdata_q;
         end
      endcase
   end

   always_comb begin
      ld_shift_d = mem_q[idx_q] >> {off_q, 3'b000};
      case (size_q)
         2'b00:   ld_val_d = {{24{~uns_q & ld_shift_d[7]}}, ld_shift_d[7:0]};
         2'b01:   ld_val_d = {{16{~uns_q & ld_shift_d[15]}}, ld_shift_d[15:0]};
         default: ld_val_d = ld_shift_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en_d && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (st_mask_d[b]) mem_q[idx_q][8*b +: 8] <= st_data_d[8*b +: 8];
         end
      end
   end

   // Faulty requests also pass through WAIT (counter forced to 0) so that their
   // done pulse lands one cycle after acceptance; fault_q suppresses the access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         fault_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               err_q <= 1'b0;
               if (req) begin
                  we_q    <= we;
                  uns_q   <= uns;
                  size_q  <= size;
                  off_q   <= addr[1:0];
                  idx_q   <= addr[AW+1:2];
                  wdata_q <= wdata;
                  fault_q <= illegal_d || range_d;
                  cnt_q   <= (illegal_d || range_d) ? 3'd0 : 3'(WAIT_CYCLES);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != 3'd0) begin
                  cnt_q <= cnt_q - 3'd1;
               end else begin
                  err_q   <= fault_q;
                  state_q <= S_RESP;
                  if (access_d && !we_q) rdata_q <= ld_val_d;
               end
            end
            S_RESP: begin
               err_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_RESP);
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
//  tb_data_mem_ctrl : directed vector bench for data_mem_ctrl (WAIT 1, 3, 0).
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_s   [3];
   logic        req_s   [3];
   logic        we_s    [3];
   logic [31:0] addr_s  [3];
   logic [1:0]  size_s  [3];
   logic        uns_s   [3];
   logic [31:0] wdata_s [3];
   logic        busy_s  [3];
   logic        done_s  [3];
   logic        err_s   [3];
   logic [31:0] rdata_s [3];

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH_WORDS(128), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
      .size(size_s[0]), .uns(uns_s[0]), .wdata(wdata_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .err(err_s[0]), .rdata(rdata_s[0]));

   data_mem_ctrl #(.DEPTH_WORDS(128), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
      .size(size_s[1]), .uns(uns_s[1]), .wdata(wdata_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .err(err_s[1]), .rdata(rdata_s[1]));

   data_mem_ctrl #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
      .size(size_s[2]), .uns(uns_s[2]), .wdata(wdata_s[2]), .busy(busy_s[2]),
      .done(done_s[2]), .err(err_s[2]), .rdata(rdata_s[2]));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // One access on instance s; inputs are scrambled right after acceptance.
   task automatic do_acc(input int s, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] wd,
                         output int lat, output logic e, output logic [31:0] rd);
      @(negedge clk);
      req_s[s] = 1'b1; we_s[s] = w; addr_s[s] = a; size_s[s] = sz;
      uns_s[s] = u; wdata_s[s] = wd;
      @(posedge clk);
      #1;
      req_s[s] = 1'b0; we_s[s] = ~w; addr_s[s] = $urandom; size_s[s] = ~sz;
      uns_s[s] = ~u; wdata_s[s] = $urandom;
      lat = 0; e = 1'bx; rd = 32'hx;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done_s[s]) begin
            lat = i; e = err_s[s]; rd = rdata_s[s];
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t        tbl [25];
   int          lat;
   logic        e;
   logic [31:0] rd;
   int          exp_done [6] = '{0, 1, 0, 0, 1, 0};

   initial begin
      tbl[0]  = '{1'b1, 32'h10,       2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 2};
      tbl[1]  = '{1'b0, 32'h10,       2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2};
      tbl[2]  = '{1'b1, 32'h13,       2'd0, 1'b0, 32'h12345680, 1'b0, 32'hDEADBEEF, 2};
      tbl[3]  = '{1'b0, 32'h10,       2'd2, 1'b0, 32'h0,        1'b0, 32'h80ADBEEF, 2};
      tbl[4]  = '{1'b0, 32'h13,       2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80, 2};
      tbl[5]  = '{1'b0, 32'h13,       2'd0, 1'b1, 32'h0,        1'b0, 32'h00000080, 2};
      tbl[6]  = '{1'b0, 32'h10,       2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFFBEEF, 2};
      tbl[7]  = '{1'b0, 32'h12,       2'd1, 1'b1, 32'h0,        1'b0, 32'h000080AD, 2};
      tbl[8]  = '{1'b0, 32'h11,       2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFBE, 2};
      tbl[9]  = '{1'b0, 32'h11,       2'd1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFBE, 1};
      tbl[10] = '{1'b1, 32'h12,       2'd2, 1'b0, 32'h11111111, 1'b1, 32'hFFFFFFBE, 1};
      tbl[11] = '{1'b0, 32'h10,       2'd2, 1'b0, 32'h0,        1'b0, 32'h80ADBEEF, 2};
      tbl[12] = '{1'b1, 32'h16,       2'd1, 1'b0, 32'hAAAA1234, 1'b0, 32'h80ADBEEF, 2};
      tbl[13] = '{1'b1, 32'h15,       2'd0, 1'b0, 32'h00000056, 1'b0, 32'h80ADBEEF, 2};
      tbl[14] = '{1'b0, 32'h14,       2'd2, 1'b0, 32'h0,        1'b0, 32'h12345600, 2};
      tbl[15] = '{1'b0, 32'h14,       2'd1, 1'b0, 32'h0,        1'b0, 32'h00005600, 2};
      tbl[16] = '{1'b0, 32'h14,       2'd3, 1'b0, 32'h0,        1'b1, 32'h00005600, 1};
      tbl[17] = '{1'b1, 32'h200,      2'd2, 1'b0, 32'hCAFEF00D, 1'b1, 32'h00005600, 1};
      tbl[18] = '{1'b0, 32'h000,      2'd2, 1'b0, 32'h0,        1'b0, 32'h00000000, 2};
      tbl[19] = '{1'b1, 32'h1FC,      2'd2, 1'b0, 32'h01020304, 1'b0, 32'h00000000, 2};
      tbl[20] = '{1'b0, 32'h1FF,      2'd0, 1'b0, 32'h0,        1'b0, 32'h00000001, 2};
      tbl[21] = '{1'b0, 32'h1FE,      2'd1, 1'b0, 32'h0,        1'b0, 32'h00000102, 2};
      tbl[22] = '{1'b0, 32'h80000010, 2'd2, 1'b0, 32'h0,        1'b1, 32'h00000102, 1};
      tbl[23] = '{1'b1, 32'h15,       2'd1, 1'b0, 32'h0000FFFF, 1'b1, 32'h00000102, 1};
      tbl[24] = '{1'b0, 32'h14,       2'd2, 1'b0, 32'h0,        1'b0, 32'h12345600, 2};

      for (int s = 0; s < 3; s++) begin
         rst_s[s] = 1'b1; req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = 32'h0;
         size_s[s] = 2'b00; uns_s[s] = 1'b0; wdata_s[s] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",  {31'h0, busy_s[0]}, 32'h0);
      chk("reset_done",  {31'h0, done_s[0]}, 32'h0);
      chk("reset_err",   {31'h0, err_s[0]},  32'h0);
      chk("reset_rdata", rdata_s[0],         32'h0);
      for (int s = 0; s < 3; s++) rst_s[s] = 1'b0;

      for (int i = 0; i < 25; i++) begin
         do_acc(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, lat, e, rd);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("vec%0d_err", i),     {31'h0, e}, {31'h0, tbl[i].err});
         chk($sformatf("vec%0d_rdata", i),   rd, tbl[i].rdata);
         chk($sformatf("vec%0d_idle", i),    {30'h0, busy_s[0], done_s[0]}, 32'h0);
      end

      // Reset in the second WAIT cycle aborts a store (WAIT_CYCLES = 3).
      do_acc(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hAAAA5555, lat, e, rd);
      chk("w3_store_latency", 32'(lat), 32'd4);
      do_acc(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, lat, e, rd);
      chk("w3_load_rdata", rd, 32'hAAAA5555);
      @(negedge clk);
      req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h20; size_s[1] = 2'd2;
      wdata_s[1] = 32'h12345678;
      @(posedge clk);
      #1;
      req_s[1] = 1'b0;
      chk("w3_busy_after_accept", {31'h0, busy_s[1]}, 32'h1);
      @(posedge clk);
      #1;
      rst_s[1] = 1'b1;
      @(posedge clk);
      #1;
      rst_s[1] = 1'b0;
      chk("w3_abort_busy",  {31'h0, busy_s[1]}, 32'h0);
      chk("w3_abort_done",  {31'h0, done_s[1]}, 32'h0);
      chk("w3_abort_rdata", rdata_s[1],         32'h0);
      do_acc(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, lat, e, rd);
      chk("w3_after_abort_latency", 32'(lat), 32'd4);
      chk("w3_after_abort_rdata",   rd,       32'hAAAA5555);

      // req held high for 6 edges with WAIT_CYCLES = 0: one acceptance per IDLE visit.
      @(negedge clk);
      req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 32'h0; size_s[2] = 2'd2;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold_done_edge%0d", i), {31'h0, done_s[2]}, 32'(exp_done[i]));
      end
      req_s[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("hold_final_idle", {30'h0, busy_s[2], done_s[2]}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL be parametrised as follows (name, default, meaning).
- DEPTH_WORDS, 128, number of 32-bit words; power of two, 16..4096.
- WAIT_CYCLES, 1, extra access wait states; 0..7.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. Ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on posedge.
- rst, in, 1, synchronous active-high reset.
- req, in, 1, access request; sampled only in IDLE.
- we, in, 1, 1 = store, 0 = load.
- addr, in, 32, byte address.
- size, in, 2, access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- uns, in, 1, load extension: 1 = zero-extend, 0 = sign-extend.
- wdata, in, 32, store data, right-aligned: byte in [7:0], half in [15:0].
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, error flag; valid only while done = 1.
- rdata, out, 32, load result; held until the next done.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-004 In IDLE, when req = 1 at a posedge, the block SHALL latch we, addr, size, uns and wdata.
REQ-005 Error checks at acceptance:
- Illegal if size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 00.
- Out of range if addr[31:2] >= DEPTH_WORDS.
- Either case: go to RESP with err = 1; memory SHALL NOT change; rdata SHALL keep its previous value.
REQ-006 A legal request at acceptance SHALL go to WAIT and load the wait counter with WAIT_CYCLES.
REQ-007 In WAIT, each posedge with counter != 0 SHALL decrement the counter.
REQ-008 In WAIT, the posedge with counter = 0 SHALL perform the access and go to RESP with err = 0.
REQ-009 Acceptance to done latency:
- Legal access: done rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
- Error: done rises 1 cycle after the accepting edge.
REQ-010 In RESP, done SHALL be 1; the next posedge SHALL return to IDLE with done = 0. Back-to-back acceptance is not possible; req is ignored in WAIT and RESP.
REQ-011 Store byte lanes:
- Byte: lane addr[1:0] written with wdata[7:0].
- Half: lanes {addr[1],0} and {addr[1],1} written with wdata[15:0], little-endian.
- Word: all four lanes written.
- All other lanes SHALL be unchanged.
REQ-012 Load: the selected byte, half or word SHALL be extracted little-endian into rdata[7:0], [15:0] or [31:0].
- uns = 0: upper bits sign-extended.
- uns = 1: upper bits zero-extended.
REQ-013 A store SHALL leave rdata unchanged.
REQ-014 Memory SHALL be a synchronous-write register array of DEPTH_WORDS x 32, initialised to zero at time zero. Memory contents SHALL be unaffected by rst.
REQ-015 Inputs SHALL NOT be re-sampled during WAIT; input changes after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-016 When rst = 1 at a posedge, the block SHALL go to IDLE and clear busy, done, err, rdata and the wait counter to 0.
REQ-017 rst SHALL take priority over req and over any access in flight. A store aborted in WAIT before its access edge SHALL NOT modify memory.
REQ-018 The first request SHALL be accepted on the first posedge with rst = 0 and req = 1.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (stimulus -> required response).
- Word store then load, WAIT_CYCLES = 1: store 0xDEADBEEF at addr 0x10 -> done 2 cycles after acceptance. Word load from 0x10 -> rdata = 0xDEADBEEF, err = 0.
- Byte and half lanes: store byte 0x80 at 0x13 over 0xDEADBEEF -> word = 0x80ADBEEF.
  - Load byte 0x13, uns = 0 -> 0xFFFFFF80; uns = 1 -> 0x00000080.
  - Load half 0x10, uns = 0 -> 0xFFFFBEEF.
- Misaligned: half load at 0x11 -> done 1 cycle after acceptance, err = 1, rdata unchanged. Word store at 0x12 -> memory unchanged.
- Out of range, DEPTH_WORDS = 128: word store at 0x200 -> err = 1; word at 0x000 unchanged.
- Reset mid-operation, WAIT_CYCLES = 3: store 0x12345678 to 0x20; assert rst in the 2nd WAIT cycle -> busy = 0 next cycle; later load of 0x20 returns its prior value.
- Busy ignore: hold req = 1 for 6 cycles with WAIT_CYCLES = 0 -> exactly one acceptance per IDLE visit, i.e. done every 3 cycles.
